// File: rtl/l2_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_responder
// Purpose  : L1-D facing line responder backed by a direct-mapped, write-back,
//            write-allocate L2 line store and a main-memory line port.
// Revision : 1.0 - initial release
// ============================================================================
module l2_line_responder #(
    parameter int NUM_SETS = 64,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 27 - IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  l2_addr,
    input  logic         l2_request,
    input  logic         l2_write_en,
    input  logic [255:0] l2_write_data,
    output logic [255:0] l2_data,
    output logic         l2_done,
    output logic [31:0]  mem_addr,
    output logic         mem_req,
    output logic         mem_we,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_ack,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_lookup = 3'd1;
    localparam logic [2:0] c_st_evict  = 3'd2;
    localparam logic [2:0] c_st_fill   = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    // Transaction inputs captured in IDLE; line address only, offset dropped
    logic [26:0]         r_line;
    logic                r_we;
    logic [255:0]        r_wdata;

    logic [255:0]        r_data_mem [NUM_SETS];
    logic [TAG_W-1:0]    r_tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [255:0]        r_rd_data;
    logic [TAG_W-1:0]    r_rd_tag;

    logic [255:0]        r_l2_data;
    logic                r_l2_done;
    logic [31:0]         r_mem_addr;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [255:0]        r_mem_wdata;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [255:0]        w_l2_data_nxt;
    logic                w_l2_done_nxt;
    logic [31:0]         w_mem_addr_nxt;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [255:0]        w_mem_wdata_nxt;
    logic [31:0]         w_hit_nxt;
    logic [31:0]         w_miss_nxt;

    logic                w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_in_idx;
    logic                w_hit;
    logic                w_victim_dirty;
    logic                w_arr_we;
    logic                w_arr_from_mem;
    logic [255:0]        w_arr_wdata;
    logic                w_unused_addr_bits;

    assign w_accept       = (r_state == c_st_idle) && l2_request;
    assign w_idx          = r_line[IDX_W-1:0];
    assign w_tag          = r_line[26:IDX_W];
    assign w_in_idx       = l2_addr[5+IDX_W-1:5];
    assign w_hit          = r_valid[w_idx] && (r_rd_tag == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_arr_wdata    = w_arr_from_mem ? mem_rdata : r_wdata;
    assign w_unused_addr_bits = ^l2_addr[4:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_l2_data_nxt   = r_l2_data;
        w_l2_done_nxt   = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        w_hit_nxt       = r_hit_count;
        w_miss_nxt      = r_miss_count;
        w_arr_we        = 1'b0;
        w_arr_from_mem  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (l2_request) begin
                    w_state_nxt = c_st_lookup;
                end
            end
            c_st_lookup: begin
                if (w_hit) begin
                    w_hit_nxt     = r_hit_count + 32'd1;
                    w_state_nxt   = c_st_resp;
                    w_l2_done_nxt = 1'b1;
                    if (r_we) begin
                        w_arr_we = 1'b1;
                    end else begin
                        w_l2_data_nxt = r_rd_data;
                    end
                end else begin
                    w_miss_nxt = r_miss_count + 32'd1;
                    if (w_victim_dirty) begin
                        w_mem_addr_nxt  = {r_rd_tag, w_idx, 5'b0};
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = r_rd_data;
                        w_mem_req_nxt   = 1'b1;
                        w_state_nxt     = c_st_evict;
                    end else if (!r_we) begin
                        w_mem_addr_nxt = {r_line, 5'b0};
                        w_mem_we_nxt   = 1'b0;
                        w_mem_req_nxt  = 1'b1;
                        w_state_nxt    = c_st_fill;
                    end else begin
                        // Full-line write needs no fill from memory
                        w_arr_we      = 1'b1;
                        w_state_nxt   = c_st_resp;
                        w_l2_done_nxt = 1'b1;
                    end
                end
            end
            c_st_evict: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    if (r_we) begin
                        w_arr_we      = 1'b1;
                        w_state_nxt   = c_st_resp;
                        w_l2_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_st_fill;
                    end
                end
            end
            c_st_fill: begin
                // Arriving from EVICT the request is low: raise it after the gap cycle
                if (!r_mem_req) begin
                    w_mem_addr_nxt = {r_line, 5'b0};
                    w_mem_we_nxt   = 1'b0;
                    w_mem_req_nxt  = 1'b1;
                end else if (mem_ack) begin
                    w_mem_req_nxt  = 1'b0;
                    w_arr_we       = 1'b1;
                    w_arr_from_mem = 1'b1;
                    w_l2_data_nxt  = mem_rdata;
                    w_state_nxt    = c_st_resp;
                    w_l2_done_nxt  = 1'b1;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (reset) begin
            w_arr_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_l2_data    <= '0;
            r_l2_done    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_valid      <= '0;
            r_dirty      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_l2_data    <= w_l2_data_nxt;
            r_l2_done    <= w_l2_done_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_hit_count  <= w_hit_nxt;
            r_miss_count <= w_miss_nxt;
            if (w_arr_we) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= !w_arr_from_mem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line  <= l2_addr[31:5];
            r_we    <= l2_write_en;
            r_wdata <= l2_write_data;
        end
    end

    // Tag/data arrays: synchronous read and write, no reset
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_data_mem[w_idx] <= w_arr_wdata;
            r_tag_mem[w_idx]  <= w_tag;
        end
        if (w_accept) begin
            r_rd_data <= r_data_mem[w_in_idx];
            r_rd_tag  <= r_tag_mem[w_in_idx];
        end
    end

    assign l2_data    = r_l2_data;
    assign l2_done    = r_l2_done;
    assign mem_addr   = r_mem_addr;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_l2_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_line_responder
// Purpose  : Randomized transaction bench with a set-level cache/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_line_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  l2_addr;
    logic         l2_request;
    logic         l2_write_en;
    logic [255:0] l2_write_data;
    logic [255:0] l2_data;
    logic         l2_done;
    logic [31:0]  mem_addr;
    logic         mem_req;
    logic         mem_we;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    l2_line_responder dut (
        .clk           (clk),
        .reset         (reset),
        .l2_addr       (l2_addr),
        .l2_request    (l2_request),
        .l2_write_en   (l2_write_en),
        .l2_write_data (l2_write_data),
        .l2_data       (l2_data),
        .l2_done       (l2_done),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: one entry per set plus a sparse main memory
    bit           m_valid [64];
    bit           m_dirty [64];
    logic [20:0]  m_tag   [64];
    logic [255:0] m_data  [64];
    logic [31:0]  m_hits;
    logic [31:0]  m_misses;
    logic [255:0] mem_m [logic [31:0]];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {4{a, ~a}};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = '0;
        m_misses = '0;
    endtask

    // One L1 transaction. chain: request already held high from previous done.
    // keep: leave request high after done so the next call chains.
    task automatic txn(input logic [31:0] a, input logic we, input logic [255:0] wd,
                       input bit chain, input bit keep);
        logic [5:0]   idx;
        logic [20:0]  tg;
        logic [31:0]  la;
        bit           hit;
        int           nops;
        logic         op_we [2];
        logic [31:0]  op_a  [2];
        logic [255:0] op_d  [2];
        logic [255:0] exp_data;
        int           lat0, opi, wcnt;
        bit           in_op, acked, fin, exp_done;

        idx  = a[10:5];
        tg   = a[31:11];
        la   = {a[31:5], 5'b0};
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        nops = 0;
        if (!hit && m_valid[idx] && m_dirty[idx]) begin
            op_we[0] = 1'b1;
            op_a[0]  = {m_tag[idx], idx, 5'b0};
            op_d[0]  = m_data[idx];
            nops     = 1;
        end
        if (!hit && !we) begin
            op_we[nops] = 1'b0;
            op_a[nops]  = la;
            op_d[nops]  = mem_line(la);
            nops++;
        end
        exp_data = hit ? m_data[idx] : mem_line(la);
        if (hit) m_hits = m_hits + 32'd1;
        else     m_misses = m_misses + 32'd1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (we) begin
            m_data[idx]  = wd;
            m_dirty[idx] = 1'b1;
        end else if (!hit) begin
            m_data[idx]  = exp_data;
            m_dirty[idx] = 1'b0;
        end

        if (!chain) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rnd256();
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        l2_request    = 1'b1;
        l2_addr       = a | 32'($urandom_range(0, 31));
        l2_write_en   = we;
        l2_write_data = wd;
        lat0  = chain ? 3 : 2;
        opi   = 0;
        in_op = 1'b0;
        acked = 1'b0;
        fin   = 1'b0;
        wcnt  = 0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            exp_done = 1'b0;
            if (acked) begin
                chk("mem_req_drop", mem_req, 1'b0);
                mem_ack = 1'b0;
                acked   = 1'b0;
                opi++;
                if (opi == nops) exp_done = 1'b1;
            end else if (nops == 0 && c == lat0) begin
                exp_done = 1'b1;
            end
            chk("l2_done", l2_done, exp_done);
            if (l2_done || exp_done) begin
                fin = 1'b1;
                if (!we) chk("l2_data", l2_data, exp_data);
                chk("hit_count", hit_count, m_hits);
                chk("miss_count", miss_count, m_misses);
                if (opi != nops) chk("mem_ops_done", 32'(opi), 32'(nops));
            end else begin
                if (c >= lat0 - 1) begin
                    l2_addr       = $urandom;
                    l2_write_en   = 1'($urandom_range(0, 1));
                    l2_write_data = rnd256();
                end
                if (mem_req) begin
                    if (!in_op) begin
                        if (opi >= nops) begin
                            chk("unexpected_mem_req", mem_req, 1'b0);
                            fin = 1'b1;
                        end else begin
                            chk("mem_we", mem_we, op_we[opi]);
                            chk("mem_addr", mem_addr, op_a[opi]);
                            if (op_we[opi]) chk("mem_wdata", mem_wdata, op_d[opi]);
                            in_op = 1'b1;
                            wcnt  = $urandom_range(0, 3);
                        end
                    end
                    if (in_op) begin
                        if (wcnt == 0) begin
                            mem_ack   = 1'b1;
                            mem_rdata = op_we[opi] ? rnd256() : op_d[opi];
                            if (op_we[opi]) mem_m[op_a[opi]] = op_d[opi];
                            in_op = 1'b0;
                            acked = 1'b1;
                        end else begin
                            wcnt--;
                        end
                    end
                end else if (in_op) begin
                    chk("mem_req_held", mem_req, 1'b1);
                    in_op = 1'b0;
                end
            end
        end
        if (!fin) chk("done_timeout", 1'b0, 1'b1);
        mem_ack = 1'b0;
        if (!keep) begin
            l2_request = 1'b0;
            l2_addr    = $urandom;
        end
    endtask

    logic [255:0] line_a, line_b;
    bit           held;

    initial begin
        reset         = 1'b1;
        l2_request    = 1'b0;
        l2_addr       = '0;
        l2_write_en   = 1'b0;
        l2_write_data = '0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;
        model_reset();
        line_a = {8{32'hAAAA_0001}};
        line_b = {8{32'hBBBB_0002}};
        mem_m[32'h0000_1000] = line_a;
        repeat (3) @(negedge clk);
        chk("rst_done", l2_done, 1'b0);
        chk("rst_data", l2_data, '0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_hits", hit_count, '0);
        chk("rst_misses", miss_count, '0);
        reset = 1'b0;

        // Directed scenarios with literal expectations
        txn(32'h0000_1000, 1'b0, '0, 1'b0, 1'b0);
        chk("lit_miss1", miss_count, 32'd1);
        chk("lit_dataA", l2_data, line_a);
        txn(32'h0000_1000, 1'b0, '0, 1'b0, 1'b0);
        chk("lit_hit1", hit_count, 32'd1);
        chk("lit_dataA_hit", l2_data, line_a);
        txn(32'h0000_1000, 1'b1, line_b, 1'b0, 1'b0);
        txn(32'h0008_1000, 1'b0, '0, 1'b0, 1'b0);
        chk("lit_miss2", miss_count, 32'd2);
        chk("lit_hit2", hit_count, 32'd2);
        txn(32'h0010_2000, 1'b1, rnd256(), 1'b0, 1'b1);
        txn(32'h0020_2000, 1'b0, '0, 1'b1, 1'b0);
        chk("lit_chain_data", l2_data, {4{32'h0020_2000, ~32'h0020_2000}});

        // Reset while a fill is outstanding
        @(negedge clk);
        l2_request  = 1'b1;
        l2_addr     = 32'h0030_0040;
        l2_write_en = 1'b0;
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
        chk("fill_req_seen", mem_req, 1'b1);
        reset      = 1'b1;
        l2_request = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_req", mem_req, 1'b0);
        chk("rstmid_done", l2_done, 1'b0);
        chk("rstmid_hits", hit_count, '0);
        chk("rstmid_misses", miss_count, '0);
        reset = 1'b0;
        model_reset();
        txn(32'h0030_0040, 1'b0, '0, 1'b0, 1'b0);
        chk("lit_post_rst_miss", miss_count, 32'd1);

        // Hit counter wrap
        @(negedge clk);
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_count;
        m_hits = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("preload_hits", hit_count, 32'hFFFF_FFFF);
        txn(32'h0030_0040, 1'b0, '0, 1'b0, 1'b0);
        chk("lit_hit_wrap", hit_count, 32'd0);

        // Randomized traffic on a few sets and tags to force hits and evictions
        held = 1'b0;
        for (int t = 0; t < 200; t++) begin
            logic [31:0] ra;
            bit          k;
            ra = {21'h100 + 21'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 5'b0};
            k  = (t != 199) && ($urandom_range(0, 3) == 0);
            txn(ra, 1'($urandom_range(0, 1)), rnd256(), held, k);
            held = k;
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Responder end of the L1-D to L2 line interface: accepts 256-bit line reads and line writebacks from the L1 data cache and answers them on l2_data / l2_done.
- Internally a direct-mapped, write-back, write-allocate L2 line store backed by a main-memory line port.
- Sits between l1_dcache and the memory controller.
- Also exports hit/miss counters for performance monitoring.

Parameters:
- NUM_SETS, 64, number of direct-mapped lines; power of two, at least 2.
- IDX_W, log2(NUM_SETS) = 6, index width.
- TAG_W, 27 - IDX_W = 21, tag width, taken from addr[31:5+IDX_W].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- l2_addr  in  32  line address from L1; bits [4:0] are ignored.
- l2_request  in  1  level request from L1; held high until L1 samples l2_done.
- l2_write_en  in  1  1 = line writeback, 0 = line read; qualified by l2_request.
- l2_write_data  in  256  writeback line.
- l2_data  out  256  read line; valid while l2_done = 1.
- l2_done  out  1  single-cycle completion pulse.
- mem_addr  out  32  memory line address, bits [4:0] = 0.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write victim line, 0 = read fill line.
- mem_wdata  out  256  victim line.
- mem_rdata  in  256  fill line; valid with mem_ack.
- mem_ack  in  1  single-cycle memory completion.
- hit_count  out  32  number of lookups that hit.
- miss_count  out  32  number of lookups that missed.

Behaviour:
- Reset values:
  - State goes to IDLE.
  - All outputs are 0: l2_data, l2_done, mem_addr, mem_req, mem_we, mem_wdata, hit_count, miss_count.
  - All valid and dirty bits are cleared in one cycle; the data and tag arrays are not cleared.
  - Reset mid-transaction abandons the transaction immediately and does not update the arrays.
- Storage:
  - Per set: tag, data, valid, dirty.
  - The data array uses a registered read (one-cycle latency) so it infers BRAM.
  - index = l2_addr[5+IDX_W-1:5], tag = l2_addr[31:5+IDX_W].
- States: IDLE, LOOKUP, EVICT, FILL, RESP.
- IDLE:
  - If l2_request = 1, latch addr, write_en and write_data, issue the array read, and go to LOOKUP.
  - l2_done = 0 throughout IDLE.
- LOOKUP: hit = valid && stored tag == latched tag.
  - Hit on a read: l2_data <= stored line, go to RESP, hit_count += 1.
  - Hit on a write: overwrite the line, set dirty = 1, go to RESP, hit_count += 1.
  - Miss: miss_count += 1.
    - If the victim is valid and dirty: mem_addr = {victim tag, index, 5'b0}, mem_we = 1, mem_wdata = victim line, mem_req = 1, go to EVICT.
    - Otherwise, on a read: mem_addr = {addr[31:5], 5'b0}, mem_we = 0, mem_req = 1, go to FILL.
    - Otherwise, on a write: install the line with valid = 1, dirty = 1 (no memory read, since the write covers the full line), go to RESP.
- EVICT:
  - On mem_ack, drop mem_req and mem_we.
  - On a read: re-issue mem_req with mem_we = 0 and the fill address, go to FILL.
  - On a write: install the new line as dirty and go to RESP.
  - At least one cycle of mem_req = 0 separates the two memory transactions.
- FILL:
  - On mem_ack, drop mem_req, install mem_rdata with valid = 1, dirty = 0, set l2_data <= mem_rdata, go to RESP.
- RESP:
  - l2_done = 1 for exactly this one cycle; l2_data stays stable during it.
  - Next state is IDLE unconditionally.
  - l2_request may still be high in the cycle after RESP (L1 chains a writeback directly into a fill with request held high). IDLE treats it as a new transaction using the current l2_write_en and l2_addr.
- Latency, with request first seen in IDLE at cycle N:
  - Hit: l2_done at cycle N+2.
  - Clean read miss: l2_done at the cycle after mem_ack + 1.
  - Write miss with clean victim: l2_done at N+2.
- Ordering and robustness:
  - Inputs latched in IDLE are used for the whole transaction; changes to l2_addr, l2_write_en or l2_write_data mid-transaction are ignored.
  - mem_ack arriving outside EVICT or FILL is ignored.
  - Both counters wrap modulo 2^32.
  - A write hit to a dirty line stays dirty and does not evict.

Test Plan:
- After reset, read 0x0000_1000 → miss_count = 1; mem read of 0x0000_1000 with mem_rdata = line A; l2_done pulses one cycle with l2_data = A; line stored clean.
- Read 0x0000_1000 again → l2_done exactly 2 cycles after request, l2_data = A, hit_count = 1, no mem_req.
- Write line B to 0x0000_1000 (hit) → done at +2; then read 0x0008_1000 (same index 0, different tag) → mem write of B to 0x0000_1000 first, then mem read of 0x0008_1000; data correct; miss_count = 2.
- Chained L1 pattern: writeback to 0x0010_2000, then request held high with l2_write_en dropping the cycle after done, reading 0x0020_2000 → two separate l2_done pulses, second returns the memory fill.
- Assert reset during FILL while mem_req = 1 → mem_req = 0, l2_done = 0, counters = 0 next cycle; a subsequent read of the same address misses.
- Run 2^32 hits via counter force/preload to 0xFFFF_FFFF, then one more hit → hit_count wraps to 0.
